// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc+4, instruction} holding buffer; clear wins over load.
module if_skid_buf
  import if_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] next_pc4,
  input  logic [31:0] next_instr,
  output logic        full,
  output logic [31:0] pc4,
  output logic [31:0] instr
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full  <= 1'b0;
      pc4   <= 32'h0;
      instr <= NOP_WORD;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      pc4   <= next_pc4;
      instr <= next_instr;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ready, feeds IF/ID.
// Optional IF_PERF_CNT_EN adds fetch and bubble counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        flush_o,
  output logic        hold_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  state_e      state, state_n;
  logic [31:0] pc_q, pc_n, pc_plus4;
  logic        buf_load, buf_clear, buf_full;
  logic [31:0] buf_pc4, buf_instr;
  logic        live_resp;

  if_skid_buf u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (buf_load),
    .clear      (buf_clear),
    .next_pc4   (pc_plus4),
    .next_instr (imem_data_i),
    .full       (buf_full),
    .pc4        (buf_pc4),
    .instr      (buf_instr)
  );

  assign pc_plus4    = pc_q + 32'd4;
  assign live_resp   = rst_i & (state == FETCH) & imem_ready_i;
  assign valid_o     = rst_i & (buf_full | live_resp);
  assign pc_plus4_o  = buf_full ? buf_pc4 : pc_plus4;
  assign instr_o     = buf_full ? buf_instr : imem_data_i;
  assign imem_req_o  = rst_i & (state != HOLD);
  assign imem_addr_o = pc_q;
  // A bubble is only loaded when IF/ID is free to take it.
  assign flush_o     = branch_taken_i | (rst_i & ~valid_o & ~stall_i);
  assign hold_o      = stall_i & ~branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (branch_taken_i) begin
      // An unfinished request must still complete; its data is thrown away.
      pc_n      = branch_target_i;
      buf_clear = 1'b1;
      state_n   = (state != HOLD && !imem_ready_i) ? DROP : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready_i) begin
            pc_n = pc_plus4;
            if (stall_i) begin
              buf_load = 1'b1;
              state_n  = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            buf_clear = 1'b1;
            state_n   = FETCH;
          end
        end
        DROP: begin
          if (imem_ready_i) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic consume;
  assign consume = valid_o & ~stall_i & ~branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_o  <= 32'h0;
      bubble_cnt_o <= 32'h0;
    end else begin
      if (consume) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (flush_o && !branch_taken_i) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule
